// File: rtl/instr_enc_pkg.sv
// Shared constants for the instruction stream encoder.
// Contents: MIPS opcode and func codes, symbolic record kinds (0-10),
// and the encoder FSM state encoding. The opcode/func values are the
// same ones the pipeline decoder's tables use.
package instr_enc_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_NEW = 6'b111111;

  // Record kinds carried on in_kind; codes 11-15 are illegal.
  typedef enum logic [3:0] {
    K_NOP = 4'd0,
    K_ADD = 4'd1,
    K_SUB = 4'd2,
    K_NEW = 4'd3,
    K_ORI = 4'd4,
    K_LUI = 4'd5,
    K_LW  = 4'd6,
    K_SW  = 4'd7,
    K_BEQ = 4'd8,
    K_JAL = 4'd9,
    K_JR  = 4'd10
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: turns one symbolic instruction record into a
// 32-bit MIPS machine word.
// Ports:
//   kind   - record kind (see kind_e); 11-15 are illegal
//   rs/rt/rd, imm16, imm26 - instruction fields; fields the kind does not
//            use are ignored
//   word   - encoded instruction (0 for nop and for illegal kinds)
//   legal  - 1 when kind is one of the eleven defined kinds
module instr_field_packer
  import instr_enc_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (kind)
      K_NOP: word = 32'h0000_0000;
      K_ADD: word = pack_r(rs, rt, rd, FN_ADD);
      K_SUB: word = pack_r(rs, rt, rd, FN_SUB);
      K_NEW: word = pack_r(rs, rt, rd, FN_NEW);
      K_JR:  word = pack_r(rs, 5'd0, 5'd0, FN_JR);
      K_ORI: word = pack_i(OP_ORI, rs, rt, imm16);
      // lui has no source register; rs is forced to zero whatever is supplied
      K_LUI: word = pack_i(OP_LUI, 5'd0, rt, imm16);
      K_LW:  word = pack_i(OP_LW, rs, rt, imm16);
      K_SW:  word = pack_i(OP_SW, rs, rt, imm16);
      K_BEQ: word = pack_i(OP_BEQ, rs, rt, imm16);
      K_JAL: word = {OP_JAL, imm26};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: accepts symbolic instruction records over a
// valid/ready handshake, packs them into MIPS words and writes them to
// consecutive instruction-memory words starting at 0.
// Optional feature: define ENC_CHECKSUM_EN to add a running XOR checksum of
// every word written (output checksum).
// Ports:
//   clk, reset           - clock (rising edge), async active-high reset
//   in_valid / in_ready  - record handshake; one record per 2 cycles at most
//   in_kind, in_rs, in_rt, in_rd, in_imm16, in_imm26 - record contents
//   finish               - end of program request
//   im_we, im_addr, im_wdata - IM write port (im_we is a one-cycle strobe)
//   count                - words written so far (saturates at IM_DEPTH)
//   full                 - count == IM_DEPTH
//   done                 - program load finished (terminal until reset)
//   err                  - sticky: an illegal kind was received
//   checksum             - (ENC_CHECKSUM_EN only) XOR of all written words
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int IM_DEPTH = 4096,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_imm26,
  input  logic              finish,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
`ifdef ENC_CHECKSUM_EN
  output logic              err,
  output logic [31:0]       checksum
`else
  output logic              err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IM_DEPTH);

  state_e          state, state_n;
  logic [31:0]     word;
  logic            legal;
  logic [ADDR_W:0] count_inc;

  instr_field_packer u_packer (
    .kind  (in_kind),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .imm16 (in_imm16),
    .imm26 (in_imm26),
    .word  (word),
    .legal (legal)
  );

  assign count_inc = count + 1'b1;

  // Outputs decoded straight from state so that an asynchronous reset
  // removes the write strobe without waiting for a clock edge.
  assign in_ready = (state == S_IDLE);
  assign im_we    = (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign full     = (count == DEPTH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        // A record wins over finish; an illegal record is consumed in place.
        if (in_valid) begin
          if (legal) state_n = S_WRITE;
        end else if (finish) begin
          state_n = S_DONE;
        end
      end
      S_WRITE: state_n = (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
      S_FULL:  if (finish) state_n = S_DONE;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_addr  <= '0;
      im_wdata <= '0;
      count    <= '0;
      err      <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      if (state == S_IDLE && in_valid) begin
        if (legal) begin
          im_wdata <= word;
          im_addr  <= count[ADDR_W-1:0];
        end else begin
          err <= 1'b1;
        end
      end
      if (state == S_WRITE) begin
        count <= count_inc;
`ifdef ENC_CHECKSUM_EN
        checksum <= checksum ^ im_wdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [25:0] imm26;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0]   in_imm16 = '0;
  logic [25:0]   in_imm26 = '0;
  logic          finish = 1'b0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;
  logic          full, done, err;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_stream_encoder #(.IM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_kind  (in_kind),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_rd    (in_rd),
    .in_imm16 (in_imm16),
    .in_imm26 (in_imm26),
    .finish   (finish),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .count    (count),
    .full     (full),
    .done     (done),
`ifdef ENC_CHECKSUM_EN
    .err      (err),
    .checksum (checksum)
`else
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  int   model_cnt = 0;
  bit   model_err = 1'b0;
  logic [31:0] model_ck = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the instruction format rules.
  function automatic bit ref_enc(input rec_t r, output logic [31:0] w);
    logic [31:0] rs, rt, rd, i16, i26;
    rs = 32'(r.rs); rt = 32'(r.rt); rd = 32'(r.rd);
    i16 = 32'(r.imm16); i26 = 32'(r.imm26);
    w = 32'd0;
    case (int'(r.kind))
      0:  w = 32'd0;
      1:  w = (rs << 21) | (rt << 16) | (rd << 11) | 32'd32;
      2:  w = (rs << 21) | (rt << 16) | (rd << 11) | 32'd34;
      3:  w = (rs << 21) | (rt << 16) | (rd << 11) | 32'd63;
      4:  w = (32'd13 << 26) | (rs << 21) | (rt << 16) | i16;
      5:  w = (32'd15 << 26) | (rt << 16) | i16;
      6:  w = (32'd35 << 26) | (rs << 21) | (rt << 16) | i16;
      7:  w = (32'd43 << 26) | (rs << 21) | (rt << 16) | i16;
      8:  w = (32'd4 << 26) | (rs << 21) | (rt << 16) | i16;
      9:  w = (32'd3 << 26) | i26;
      10: w = (rs << 21) | 32'd8;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic rec_t mk(input int k, input int rs, input int rt, input int rd,
                              input int i16, input int i26);
    rec_t r;
    r.kind = 4'(k); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
    r.imm16 = 16'(i16); r.imm26 = 26'(i26);
    return r;
  endfunction

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && im_we) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {1'b1, 32'(im_wdata)}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("im_addr", 64'(im_addr), 64'(e.addr));
        chk("im_wdata", 64'(im_wdata), 64'(e.data));
      end
    end
  end

  // Present a record (called at a negedge); in_valid is left high.
  task automatic send(input rec_t r, output bit acc, output int acc_cyc);
    logic [31:0] w;
    bit lg;
    in_kind = r.kind; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd;
    in_imm16 = r.imm16; in_imm26 = r.imm26;
    in_valid = 1'b1;
    acc = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        lg = ref_enc(r, w);
        if (lg) begin
          q.push_back('{addr: 32'(model_cnt), data: w});
          model_cnt++;
          model_ck = model_ck ^ w;
        end else begin
          model_err = 1'b1;
        end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    finish = 1'b0;
    q.delete();
    model_cnt = 0;
    model_err = 1'b0;
    model_ck = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(model_cnt));
    chk({tag, "_full"}, 64'(full), 64'(model_cnt == DEPTH));
    chk({tag, "_err"}, 64'(err), 64'(model_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int c0, c1, c2;
    rec_t r;

    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_im_we", 64'(im_we), 64'd0);
    chk("rst_im_addr", 64'(im_addr), 64'd0);
    chk("rst_im_wdata", 64'(im_wdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk_status("rst");
`ifdef ENC_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'd0);
`endif

    // add r3 = r1 + r2
    send(mk(1, 1, 2, 3, 0, 0), acc, c0);
    chk("add_acc", 64'(acc), 64'd1);
    chk("add_we_latency", 64'(im_we), 64'd1);
    idle(1);
    chk_status("add");

    // ori then lui with a non-zero rs input
    send(mk(4, 0, 1, 0, 'h1234, 0), acc, c0);
    idle(1);
    send(mk(5, 7, 1, 9, 'hFFFF, 0), acc, c0);
    idle(1);
    chk_status("ori_lui");

    // back-to-back with in_valid held: accepts every second cycle
    send(mk(6, 0, 2, 0, 4, 0), acc, c0);
    send(mk(9, 3, 4, 5, 'h55AA, 'h0000C03), acc, c1);
    send(mk(10, 31, 6, 7, 'h1111, 'h3FFFFFF), acc, c2);
    idle(1);
    chk("b2b_gap1", 64'(c1 - c0), 64'd2);
    chk("b2b_gap2", 64'(c2 - c1), 64'd2);
    chk_status("b2b");

    // illegal kind: consumed, sticky err, no write; nop still writes
    send(mk(13, 1, 2, 3, 4, 5), acc, c0);
    chk("illegal_acc", 64'(acc), 64'd1);
    chk("illegal_no_we", 64'(im_we), 64'd0);
    idle(2);
    chk_status("illegal");
    send(mk(0, 9, 9, 9, 'hFFFF, 'h3FFFFFF), acc, c0);
    idle(1);
    chk_status("nop");

    // fill to DEPTH, then one more record must be refused
    send(mk(2, 4, 5, 6, 0, 0), acc, c0);
    idle(1);
    chk_status("fill");
    chk("full_in_ready", 64'(in_ready), 64'd0);
    send(mk(1, 1, 1, 1, 0, 0), acc, c0);
    chk("full_reject", 64'(acc), 64'd0);
    idle(1);
    chk_status("full_hold");
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("full_finish_done", 64'(done), 64'd1);
    chk("done_in_ready", 64'(in_ready), 64'd0);
    idle(2);
    chk("done_sticky", 64'(done), 64'd1);
    chk_status("done");

    // checksum and reset during a write
    do_reset();
    send(mk(1, 1, 2, 3, 0, 0), acc, c0);
    idle(1);
    send(mk(4, 0, 1, 0, 'h1234, 0), acc, c0);
    idle(1);
`ifdef ENC_CHECKSUM_EN
    chk("checksum_two", 64'(checksum), 64'h34230A14);
    chk("checksum_model", 64'(checksum), 64'(model_ck));
`endif
    send(mk(8, 3, 4, 0, 'h8000, 0), acc, c0);
    chk("pre_abort_we", 64'(im_we), 64'd1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_we", 64'(im_we), 64'd0);
    chk("abort_count", 64'(count), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
`ifdef ENC_CHECKSUM_EN
    chk("abort_checksum", 64'(checksum), 64'd0);
`endif
    @(negedge clk);
    do_reset();

    // finish together with a record: record first, finish on the next idle cycle
    finish = 1'b1;
    send(mk(7, 2, 3, 0, 'hFFFC, 0), acc, c0);
    in_valid = 1'b0;
    chk("prio_acc", 64'(acc), 64'd1);
    chk("prio_not_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    finish = 1'b0;
    chk("prio_done", 64'(done), 64'd1);
    chk_status("prio");

    // randomized program
    do_reset();
    for (int n = 0; n < 40; n++) begin
      bit exp_acc;
      r = mk(int'($urandom_range(0, 15)), int'($urandom), int'($urandom), int'($urandom),
             int'($urandom), int'($urandom));
      exp_acc = (model_cnt < DEPTH);
      send(r, acc, c0);
      chk("rand_acc", 64'(acc), 64'(exp_acc));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    chk_status("rand");
`ifdef ENC_CHECKSUM_EN
    chk("rand_checksum", 64'(checksum), 64'(model_ck));
`endif
    finish = 1'b1;
    repeat (2) @(negedge clk);
    finish = 1'b0;
    chk("rand_done", 64'(done), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Encoder for the pipeline's decode stage: it takes symbolic instruction records (kind plus fields) over a valid/ready handshake.
- Packs each record into a 32-bit MIPS machine word and writes it sequentially into instruction memory.
- Used by the test and bring-up infrastructure to load programs into IM before the pipeline runs.
- Instruction set matches the decoder exactly: add, sub, new, ori, lui, lw, sw, beq, jal, jr, plus nop.

Parameters:
- IM_DEPTH, 4096, number of IM words; the write pointer saturates here.
- ADDR_W, 12, width of the word-index address; must satisfy 2^ADDR_W >= IM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  record present.
- in_ready  out  1  encoder can accept a record this cycle.
- in_kind  in  4  0 nop, 1 add, 2 sub, 3 new, 4 ori, 5 lui, 6 lw, 7 sw, 8 beq, 9 jal, 10 jr; 11-15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm16  in  16  I-type immediate or offset.
- in_imm26  in  26  J-type target field.
- finish  in  1  end of program request.
- im_we  out  1  IM write strobe.
- im_addr  out  ADDR_W  IM word index.
- im_wdata  out  32  encoded word.
- count  out  ADDR_W+1  words written so far.
- full  out  1  count == IM_DEPTH.
- done  out  1  program load finished.
- err  out  1  sticky flag: an illegal kind was received.

Behaviour:
- Reset (asynchronous): state S_IDLE; im_we=0, im_addr=0, im_wdata=0, count=0, full=0, done=0, err=0. Reset asserted mid-write aborts that write; im_we drops immediately.
- States: S_IDLE, S_WRITE, S_FULL, S_DONE.
- S_IDLE:
  - in_ready=1.
  - in_valid=1 and legal kind: register the encoded word into im_wdata, set im_addr=count, go to S_WRITE.
  - in_valid=1 and illegal kind: record is consumed, err is set, no write, stay in S_IDLE.
  - in_valid takes priority over finish in the same cycle; finish is then honoured on the next S_IDLE cycle if still high.
  - finish=1 with in_valid=0: go to S_DONE.
- S_WRITE:
  - in_ready=0; im_we=1 for exactly one cycle.
  - Next edge: count+1, then S_FULL if count+1 == IM_DEPTH, else S_IDLE.
  - Throughput is therefore one record per 2 cycles; latency from accept to im_we is 1 cycle.
- S_FULL: in_ready=0, full=1. finish moves the block to S_DONE; in_valid is ignored.
- S_DONE: in_ready=0, done=1; terminal until reset.
- im_we is 0 in every state except S_WRITE. im_addr and im_wdata hold their last values otherwise.
- Encoding, fields packed MSB to LSB:
  - R-type (add/sub/new): op=000000, rs, rt, rd, shamt=00000, func = 100000 / 100010 / 111111.
  - jr: op=000000, rs, rt=0, rd=0, shamt=0, func=001000.
  - I-type: op = ori 001101, lui 001111 (rs forced to 0), lw 100011, sw 101011, beq 000100; then rs, rt, imm16.
  - jal: op=000011, imm26.
  - nop: 32'h00000000.
  - Unused input fields are ignored, not masked into the word.

Optional Feature:
- Macro ENC_CHECKSUM_EN.
- Defined: extra output checksum[31:0]. Reset to 0; on each im_we cycle it becomes checksum XOR im_wdata; it is held in S_DONE.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package instr_enc_pkg:
  - opcode and func constants (R, LW, SW, BEQ, LUI, ORI, JAL; ADD, SUB, JR, NEW);
  - kind codes 0-10;
  - state encodings.
  These constants are shared with the decoder's tables.
- One combinational sub-module, instr_field_packer: takes kind and fields, outputs word[31:0] and legal.
- The top level holds the FSM, count, and the IM interface.

Test Plan:
- add rs=1 rt=2 rd=3 → one im_we at addr 0 with wdata 0x00221820, then count=1.
- ori rs=0 rt=1 imm 0x1234, then lui rt=1 imm 0xFFFF (rs input 7) → 0x34011234 at addr 0, 0x3C01FFFF at addr 1 (rs forced to 0).
- lw rt=2 imm 4, jal imm26 0x0000C03, jr rs=31 back-to-back with in_valid held high → words 0x8C020004, 0x0C000C03, 0x03E00008; in_ready drops every other cycle.
- in_kind=13 → no im_we, err=1 and stays 1; a following nop still writes 0x00000000.
- IM_DEPTH=4, five records → 4 writes, full=1, in_ready=0, 5th record never accepted; finish → done=1.
- Reset asserted during S_WRITE → im_we=0 asynchronously, count=0, state S_IDLE; with ENC_CHECKSUM_EN, checksum=0 and after words 0x00221820 and 0x34011234 equals 0x34230A14.
